// File: rtl/wl_match_encoder.sv
// Encodes an active-low wordline/match vector back into row addresses, lowest row first.
// One address per cycle at full throughput; out_valid/out_ready handshake holds state while stalled.
module wl_match_encoder #(
    parameter int N_WL   = 64,
    parameter int ADDR_W = $clog2(N_WL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_WL-1:0]   wl_n,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              done,
    output logic              none,
    output logic [ADDR_W:0]   hit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N_WL-1:0] PEND_ONE = {{(N_WL-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [N_WL-1:0]   pending, pending_nxt;
    logic [ADDR_W:0]   hit_nxt;
    logic [N_WL-1:0]   pending_rest;
    logic              pend_any;
    logic              pend_single;
    logic [ADDR_W-1:0] addr_enc;

    // pending with its lowest set bit cleared; zero means at most one bit was set
    assign pending_rest = pending & (pending - PEND_ONE);
    assign pend_any     = |pending;
    assign pend_single  = pend_any && (pending_rest == '0);

    always_comb begin
        addr_enc = '0;
        for (int i = N_WL - 1; i >= 0; i--) begin
            if (pending[i]) begin
                addr_enc = ADDR_W'(i);
            end
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == SCAN) && pend_any;
    assign out_addr  = out_valid ? addr_enc : '0;
    assign out_last  = out_valid && pend_single;
    assign done      = (state == DONE);
    assign none      = done && (hit_cnt == '0);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        hit_nxt     = hit_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    pending_nxt = ~wl_n;
                    hit_nxt     = '0;
                    state_nxt   = SCAN;
                end
            end
            SCAN: begin
                if (!pend_any) begin
                    state_nxt = DONE;
                end else if (out_ready) begin
                    pending_nxt = pending_rest;
                    hit_nxt     = hit_cnt + CNT_ONE;
                    // finishing on the last handshake lets done follow it directly
                    if (pend_single) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            hit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            hit_cnt <= hit_nxt;
        end
    end

endmodule

// File: tb/tb_wl_match_encoder.sv
// Directed-vector bench for wl_match_encoder; inputs change and outputs are checked on the falling edge.
module tb_wl_match_encoder;

    localparam int N_WL   = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst;
    logic              start;
    logic [N_WL-1:0]   wl_n;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              done;
    logic              none;
    logic [ADDR_W:0]   hit_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    wl_match_encoder #(.N_WL(N_WL), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wl_n      (wl_n),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .done      (done),
        .none      (none),
        .hit_cnt   (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start with vector v; returns at the falling edge of the first SCAN cycle.
    task automatic kick(input logic [N_WL-1:0] v);
        wl_n  = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        wl_n = '1;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({busy, out_valid, out_last, done, none, out_addr, hit_cnt} !== 15'h0) begin
            err_cnt++;
            $display("FAIL reset_state: got busy=%b vld=%b last=%b done=%b none=%b addr=%0d cnt=%0d, want all 0",
                     busy, out_valid, out_last, done, none, out_addr, hit_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        kick(~(64'h1 << 5));
        vec_cnt++;
        if ({busy, out_valid, out_addr, out_last} !== {1'b1, 1'b1, 6'd5, 1'b1}) begin
            err_cnt++;
            $display("FAIL single_beat: got busy=%b vld=%b addr=%0d last=%b, want 1 1 5 1",
                     busy, out_valid, out_addr, out_last);
        end
        @(negedge clk);
        vec_cnt++;
        if ({done, none, out_valid, hit_cnt} !== {1'b1, 1'b0, 1'b0, 7'd1}) begin
            err_cnt++;
            $display("FAIL single_done: got done=%b none=%b vld=%b cnt=%0d, want 1 0 0 1",
                     done, none, out_valid, hit_cnt);
        end
        @(negedge clk);
        vec_cnt++;
        if ({busy, done, hit_cnt} !== {1'b0, 1'b0, 7'd1}) begin
            err_cnt++;
            $display("FAIL single_idle: got busy=%b done=%b cnt=%0d, want 0 0 1", busy, done, hit_cnt);
        end
    endtask

    task automatic test_all_rows();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        kick(64'h0);
        for (int i = 0; i < 64; i++) begin
            vec_cnt++;
            if (out_valid !== 1'b1 || out_addr !== ADDR_W'(i) || out_last !== (i == 63) ||
                hit_cnt !== 7'(i) || done !== 1'b0) begin
                err_cnt++;
                bad++;
                if (bad < 5)
                    $display("FAIL all_rows_beat%0d: got vld=%b addr=%0d last=%b cnt=%0d done=%b, want 1 %0d %0d %0d 0",
                             i, out_valid, out_addr, out_last, hit_cnt, done, i, (i == 63), i);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if ({done, none, out_valid, hit_cnt} !== {1'b1, 1'b0, 1'b0, 7'd64}) begin
            err_cnt++;
            $display("FAIL all_rows_done: got done=%b none=%b vld=%b cnt=%0d, want 1 0 0 64",
                     done, none, out_valid, hit_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_match();
        out_ready = 1'b1;
        kick('1);
        vec_cnt++;
        if ({busy, out_valid, done} !== 3'b100) begin
            err_cnt++;
            $display("FAIL zero_scan: got busy=%b vld=%b done=%b, want 1 0 0", busy, out_valid, done);
        end
        @(negedge clk);
        vec_cnt++;
        if ({done, none, out_valid, hit_cnt} !== {1'b1, 1'b1, 1'b0, 7'd0}) begin
            err_cnt++;
            $display("FAIL zero_done: got done=%b none=%b vld=%b cnt=%0d, want 1 1 0 0",
                     done, none, out_valid, hit_cnt);
        end
        @(negedge clk);
        vec_cnt++;
        if ({busy, done, none} !== 3'b000) begin
            err_cnt++;
            $display("FAIL zero_idle: got busy=%b done=%b none=%b, want 0 0 0", busy, done, none);
        end
    endtask

    task automatic test_backpressure();
        logic       rdy_seq  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [5:0] addr_seq [5] = '{6'd0, 6'd17, 6'd17, 6'd17, 6'd63};
        logic       last_seq [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [6:0] cnt_seq  [5] = '{7'd0, 7'd1, 7'd1, 7'd1, 7'd2};
        out_ready = 1'b0;
        kick(~((64'h1 << 0) | (64'h1 << 17) | (64'h1 << 63)));
        for (int c = 0; c < 5; c++) begin
            vec_cnt++;
            if (out_valid !== 1'b1 || out_addr !== addr_seq[c] || out_last !== last_seq[c] ||
                hit_cnt !== cnt_seq[c]) begin
                err_cnt++;
                $display("FAIL stall_cycle%0d: got vld=%b addr=%0d last=%b cnt=%0d, want 1 %0d %b %0d",
                         c, out_valid, out_addr, out_last, hit_cnt, addr_seq[c], last_seq[c], cnt_seq[c]);
            end
            out_ready = rdy_seq[c];
            @(negedge clk);
        end
        vec_cnt++;
        if ({done, none, hit_cnt} !== {1'b1, 1'b0, 7'd3}) begin
            err_cnt++;
            $display("FAIL stall_done: got done=%b none=%b cnt=%0d, want 1 0 3", done, none, hit_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_restart();
        out_ready = 1'b1;
        kick(~((64'h1 << 3) | (64'h1 << 40)));
        start = 1'b1;
        wl_n  = 64'h0;
        vec_cnt++;
        if ({out_valid, out_addr, out_last} !== {1'b1, 6'd3, 1'b0}) begin
            err_cnt++;
            $display("FAIL ignore_beat0: got vld=%b addr=%0d last=%b, want 1 3 0", out_valid, out_addr, out_last);
        end
        @(negedge clk);
        vec_cnt++;
        if ({out_valid, out_addr, out_last} !== {1'b1, 6'd40, 1'b1}) begin
            err_cnt++;
            $display("FAIL ignore_beat1: got vld=%b addr=%0d last=%b, want 1 40 1", out_valid, out_addr, out_last);
        end
        @(negedge clk);
        start = 1'b0;
        vec_cnt++;
        if ({done, hit_cnt} !== {1'b1, 7'd2}) begin
            err_cnt++;
            $display("FAIL ignore_done: got done=%b cnt=%0d, want 1 2", done, hit_cnt);
        end
        @(negedge clk);
        wl_n = '1;
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL ignore_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        out_ready = 1'b1;
        kick(64'h0);
        @(negedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({out_valid, out_addr, hit_cnt} !== {1'b1, 6'd2, 7'd2}) begin
            err_cnt++;
            $display("FAIL rst_pre: got vld=%b addr=%0d cnt=%0d, want 1 2 2", out_valid, out_addr, hit_cnt);
        end
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({busy, out_valid, out_last, done, none, out_addr, hit_cnt} !== 15'h0) begin
            err_cnt++;
            $display("FAIL rst_async: got busy=%b vld=%b last=%b done=%b none=%b addr=%0d cnt=%0d, want all 0",
                     busy, out_valid, out_last, done, none, out_addr, hit_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({busy, out_valid} !== 2'b00) begin
            err_cnt++;
            $display("FAIL rst_idle: got busy=%b vld=%b, want 0 0", busy, out_valid);
        end
        kick(~(64'h1 << 9));
        vec_cnt++;
        if ({out_valid, out_addr, out_last, hit_cnt} !== {1'b1, 6'd9, 1'b1, 7'd0}) begin
            err_cnt++;
            $display("FAIL rst_restart: got vld=%b addr=%0d last=%b cnt=%0d, want 1 9 1 0",
                     out_valid, out_addr, out_last, hit_cnt);
        end
        @(negedge clk);
        vec_cnt++;
        if ({done, none, hit_cnt} !== {1'b1, 1'b0, 7'd1}) begin
            err_cnt++;
            $display("FAIL rst_restart_done: got done=%b none=%b cnt=%0d, want 1 0 1", done, none, hit_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_rows();
        test_zero_match();
        test_backpressure();
        test_ignore_restart();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
